// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - BasicCPU datapath ALU with combinational result/status and registered flags
module alu_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            opcode,
    output logic [DATA_WIDTH-1:0] C,
    output logic [3:0]            status,
    output logic [3:0]            flags
);

    // One extra bit above the datapath captures carry-out / borrow.
    localparam logic [DATA_WIDTH:0] ONE_EXT = {{DATA_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH:0] a_ext;
    logic [DATA_WIDTH:0] b_ext;
    logic [DATA_WIDTH:0] r;

    assign a_ext = {1'b0, A};
    assign b_ext = {1'b0, B};

    // Opcode decode into the widened result; every opcode value is covered.
    always_comb begin
        r = '0;
        casez (opcode)
            5'b00000: r = a_ext;                    // LD
            5'b00001: r = a_ext + ONE_EXT;          // INC
            5'b00010: r = a_ext + b_ext;            // ADD
            5'b00011: r = a_ext + b_ext + ONE_EXT;  // ADC, fixed +1
            5'b00100: r = a_ext - b_ext - ONE_EXT;  // SBB
            5'b00101: r = a_ext - b_ext;            // SUB
            5'b00110: r = a_ext - ONE_EXT;          // DEC
            5'b00111: r = a_ext;                    // LD1
            5'b0100?: r = a_ext & b_ext;            // AND
            5'b0101?: r = a_ext | b_ext;            // OR
            5'b0110?: r = a_ext ^ b_ext;            // XOR
            5'b0111?: r = ~b_ext;                   // CMP: top bit becomes 1
            5'b10???: r = a_ext >> 1;               // RSH
            5'b11???: r = a_ext << 1;               // LSH: A msb lands in carry
            default:  r = '0;
        endcase
    end

    assign C      = r[DATA_WIDTH-1:0];
    assign status = {C[DATA_WIDTH-1], (C == '0), ^C, r[DATA_WIDTH]};

    // Flags snapshot of status for the control unit; reset wins over update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags <= 4'b0000;
        end else begin
            flags <= status;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit: directed edges, flags timing, random sweep
module tb_alu_unit;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [4:0]   opcode;
    logic [W-1:0] C;
    logic [3:0]   status;
    logic [3:0]   flags;

    int compared;
    int mismatched;

    alu_unit #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .opcode  (opcode),
        .C       (C),
        .status  (status),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: true integer arithmetic, reduced modulo 2^(W+1).
    function automatic void ref_model(input int a, input int b, input int op,
                                      output int c, output int st);
        int full;
        int modv;
        int r;
        int ones;
        int t;
        full = 1 << W;
        modv = 2 * full;
        if      (op == 0 || op == 7) r = a;
        else if (op == 1)            r = a + 1;
        else if (op == 2)            r = a + b;
        else if (op == 3)            r = a + b + 1;
        else if (op == 4)            r = a - b - 1;
        else if (op == 5)            r = a - b;
        else if (op == 6)            r = a - 1;
        else if (op < 10)            r = a & b;
        else if (op < 12)            r = a | b;
        else if (op < 14)            r = a ^ b;
        else if (op < 16)            r = (modv - 1) - b;
        else if (op < 24)            r = a / 2;
        else                         r = a * 2;
        r = ((r % modv) + modv) % modv;
        c = r % full;
        ones = 0;
        t = c;
        while (t > 0) begin
            ones += t % 2;
            t = t / 2;
        end
        st = ((c >= full / 2) ? 8 : 0) + ((c == 0) ? 4 : 0)
           + ((ones % 2) * 2) + (r / full);
    endfunction

    task automatic apply(input int a, input int b, input int op, input string tag);
        int ec;
        int es;
        A = a[W-1:0];
        B = b[W-1:0];
        opcode = op[4:0];
        #1;
        ref_model(a, b, op, ec, es);
        check({tag, ".C"}, 32'(C), ec);
        check({tag, ".status"}, 32'(status), es);
    endtask

    task automatic directed(input int a, input int b, input int op,
                            input int ec, input int es, input string tag);
        A = a[W-1:0];
        B = b[W-1:0];
        opcode = op[4:0];
        #1;
        check({tag, ".C"}, 32'(C), ec);
        check({tag, ".status"}, 32'(status), es);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        A          = 8'hFF;
        B          = 8'h01;
        opcode     = 5'h02;

        // Reset held for two edges; status stays live during reset
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_status_live", 32'(status), 32'b0101);

        // Release: flags must not update before the next edge
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("flags_before_edge", 32'(flags), 32'h0);
        @(posedge clk);
        #1;
        check("flags_after_edge", 32'(flags), 32'b0101);

        // New op, then mid-run reset
        @(negedge clk);
        A = 8'h03; B = 8'h05; opcode = 5'h05;
        @(posedge clk);
        #1;
        check("flags_sub", 32'(flags), 32'b1011);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_status_live", 32'(status), 32'b1011);
        @(posedge clk);
        #1;
        check("midreset_flags", 32'(flags), 32'h0);
        check("midreset_C_live", 32'(C), 32'hFE);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed boundary vectors
        directed(8'hFF, 8'h01, 5'h02, 8'h00, 4'b0101, "add_wrap");
        directed(8'h03, 8'h05, 5'h05, 8'hFE, 4'b1011, "sub_borrow");
        directed(8'h03, 8'h05, 5'h04, 8'hFD, 4'b1011, "sbb_borrow");
        directed(8'hFF, 8'h00, 5'h01, 8'h00, 4'b0101, "inc_wrap");
        directed(8'h00, 8'h00, 5'h06, 8'hFF, 4'b1001, "dec_zero");
        directed(8'hF0, 8'h3C, 5'h08, 8'h30, 4'b0000, "and");
        directed(8'hF0, 8'h3C, 5'h0C, 8'hCC, 4'b1000, "xor");
        directed(8'hF0, 8'h3C, 5'h0E, 8'hC3, 4'b1001, "cmp");
        directed(8'h81, 8'h00, 5'h18, 8'h02, 4'b0011, "lsh");
        directed(8'h81, 8'h00, 5'h10, 8'h40, 4'b0010, "rsh");
        directed(8'h05, 8'h05, 5'h04, 8'hFF, 4'b1001, "sbb_equal");
        directed(8'hFF, 8'hFF, 5'h03, 8'hFF, 4'b1001, "adc_max");

        // Random sweep over every opcode
        for (int op = 0; op < 32; op++) begin
            for (int n = 0; n < 1000; n++) begin
                apply(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), op,
                      $sformatf("rand_op%02h", op));
            end
        end

        // Flags track status after a random op
        @(negedge clk);
        A = 8'h80; B = 8'h80; opcode = 5'h02;
        @(posedge clk);
        #1;
        check("flags_add_80", 32'(flags), 32'b0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name:
alu_unit

Overview:
- Datapath arithmetic/logic unit of the BasicCPU core.
- Computes a DATA_WIDTH-bit result C and a 4-bit status vector {sign, zero, parity, carry} combinationally from operands A, B and a 5-bit opcode.
- Also holds a registered copy of the status (flags) for the control unit. It is clocked on clk and cleared by synchronous active-low reset.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (must be >= 2).

Ports:
- clk, input, 1, system clock; flags register updates on rising edge.
- reset_n, input, 1, synchronous active-low reset.
- A, input, DATA_WIDTH, operand A.
- B, input, DATA_WIDTH, operand B.
- opcode, input, 5, operation select.
- C, output, DATA_WIDTH, result (combinational).
- status, output, 4, {sign, zero, parity, carry} of the current result (combinational).
- flags, output, 4, registered status.

Behaviour:
Internal result
- Form a DATA_WIDTH+1-bit result R, with operands zero-extended to DATA_WIDTH+1 bits.
- C = R[DATA_WIDTH-1:0].
- carry = R[DATA_WIDTH].

Opcode map (hex)
- 00 LD: R = A.
- 01 INC: R = A+1.
- 02 ADD: R = A+B.
- 03 ADC: R = A+B+1. Fixed +1; there is no carry-in from flags.
- 04 SBB: R = A-B-1.
- 05 SUB: R = A-B.
- 06 DEC: R = A-1.
- 07 LD1: R = A.
- 08/09 AND: R = A&B.
- 0A/0B OR: R = A|B.
- 0C/0D XOR: R = A^B.
- 0E/0F CMP (complement): R = ~{0,B}. C = ~B, and carry = 1.
- 10-17 RSH: R = {0,A}>>1. MSB of C is 0; carry = 0.
- 18-1F LSH: R = {0,A}<<1. LSB of C is 0; carry = A[DATA_WIDTH-1].

Arithmetic rules
- Subtractions are modulo 2^(DATA_WIDTH+1), so carry acts as a borrow: it is 1 when the true result is negative (e.g. A<B for SUB, A=0 for DEC, A<=B for SBB).
- Addition carry is the true carry-out: INC of all-ones gives C=0, carry=1.
- Logic ops and LD/LD1 give carry = 0.

Status
- status[3] sign = C[DATA_WIDTH-1].
- status[2] zero = (C == 0).
- status[1] parity = XOR-reduction of C, i.e. 1 when C has an odd number of ones (even-parity bit).
- status[0] carry = R[DATA_WIDTH].

Timing
- C and status are purely combinational: zero latency, valid within the same delta/timestep as input changes.
- No dependency on clk or reset_n.

Flags register
- On each rising clk: if reset_n==0, flags <= 4'b0000; otherwise flags <= status.
- One-cycle latency relative to status.
- Reset takes priority over update.
- Reset has no effect on C/status.

Boundaries
- Every opcode value 00-1F is defined; there is no illegal-opcode state.
- No X propagation for known inputs.

Test Plan:
- ADD wrap: A=8'hFF, B=8'h01, op=02 -> C=00, status=0101 (zero, carry).
- SUB borrow: A=8'h03, B=8'h05, op=05 -> C=FE, status=1011 (sign, odd parity, carry). Same A/B with op=04 SBB -> C=FD, status=1011.
- INC/DEC edges: A=FF op=01 -> C=00, status=0101. A=00 op=06 -> C=FF, status=1001.
- Logic/complement: A=F0, B=3C:
  - op=08 -> C=30, status=0000.
  - op=0C -> C=CC, status=1000.
  - op=0E -> C=C3, status=1001.
- Shifts: A=8'h81:
  - op=18 -> C=02, status=0011.
  - op=10 -> C=40, status=0010.
- Flags register:
  - Hold reset_n=0 for 2 clk edges -> flags=0000.
  - Release reset, apply ADD FF+01 -> flags=0101 after the next rising edge, not before.
  - Assert reset_n=0 mid-run -> flags=0000 at the next edge, while C/status stay live.
- Random sweep: 1000 random A/B per opcode group versus a (DATA_WIDTH+1)-bit reference model -> all C/status match.
